// File: rtl/rf_transceiver_pkg.sv
// Shared types and default timing constants for the RF transceiver controller
// and its wireless-transmit framer.
package rf_transceiver_pkg;

  typedef enum logic [2:0] {IDLE, WAIT, HDR, SEND, GAP} state_t;

  localparam int DEF_START_WIRELESS_TRANS_VALUE  = 58;
  localparam int DEF_END_WAITING_SEND_WLESS_DATA = 6250;

endpackage

// File: rtl/wless_circ_buffer.sv
// Circular byte buffer for the wireless TX framer: storage, pointers,
// occupancy count, full flag and a delayed overflow pulse.
module wless_circ_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUFFER_DEPTH = 512,
  localparam int AW = $clog2(BUFFER_DEPTH),
  localparam int CW = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CW-1:0]         count,
  output logic [CW-1:0]         count_next,
  output logic                  full,
  output logic                  overflow,
  output logic                  wr_accept
);

  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic                  full_reg;
  logic                  overflow_reg;

  assign wr_accept = wr_en && !full_reg;

  always_comb begin
    count_next = count_reg;
    case ({wr_accept, rd_pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage has no reset so it maps onto RAM; stale contents are never read.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_reg] <= wr_data;
  end

  // Depth is a power of two, so pointer wrap is the natural roll-over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_pop)    rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg    <= count_next;
      full_reg     <= (count_next == CW'(BUFFER_DEPTH));
      overflow_reg <= wr_en && full_reg;
    end
  end

  assign head     = mem[rd_ptr_reg];
  assign count    = count_reg;
  assign full     = full_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/wless_tx_framer.sv
// Wireless TX framer: buffers controller bytes and streams packets into the node UART.
// Define WLESS_FRAMER_LEN_HEADER_EN to prefix each packet with a length byte.
module wless_tx_framer
  import rf_transceiver_pkg::*;
#(
  parameter int DATA_WIDTH                  = 8,
  parameter int BUFFER_DEPTH                = 512,
  parameter int START_WIRELESS_TRANS_VALUE  = DEF_START_WIRELESS_TRANS_VALUE,
  parameter int END_WAITING_SEND_WLESS_DATA = DEF_END_WAITING_SEND_WLESS_DATA,
  localparam int CW = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                  internal_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  input  logic                  tx_enable,
  input  logic                  TX_flag_node,
  output logic                  TX_use_node,
  output logic [DATA_WIDTH-1:0] data_to_uart_node,
  output logic [CW-1:0]         buffer_count,
  output logic                  buffer_full,
  output logic                  overflow,
  output logic                  frame_active,
  output logic                  AUX
);

  localparam int TW = $clog2(END_WAITING_SEND_WLESS_DATA + 1);
  localparam logic [CW-1:0] START_CNT  = CW'(START_WIRELESS_TRANS_VALUE);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(END_WAITING_SEND_WLESS_DATA);
  localparam logic [TW-1:0] TIMER_FIRE = TW'(END_WAITING_SEND_WLESS_DATA - 1);
`ifdef WLESS_FRAMER_LEN_HEADER_EN
  localparam state_t FIRST_STATE = HDR;
`else
  localparam state_t FIRST_STATE = SEND;
`endif

  state_t                state_reg, state_next;
  logic [TW-1:0]         timer_reg, timer_next;
  logic [CW-1:0]         pkt_rem_reg, pkt_rem_next;
  logic                  frame_active_reg, aux_reg;
  logic                  wr_accept, push, pop;
  logic [DATA_WIDTH-1:0] head;
  logic [CW-1:0]         count, count_next, pkt_load;

  wless_circ_buffer #(
    .DATA_WIDTH   (DATA_WIDTH),
    .BUFFER_DEPTH (BUFFER_DEPTH)
  ) u_buf (
    .clk        (internal_clk),
    .rst        (rst),
    .wr_en      (data_in_valid),
    .wr_data    (data_in),
    .rd_pop     (pop),
    .head       (head),
    .count      (count),
    .count_next (count_next),
    .full       (buffer_full),
    .overflow   (overflow),
    .wr_accept  (wr_accept)
  );

  assign push     = ((state_reg == SEND) || (state_reg == HDR)) && tx_enable && !TX_flag_node;
  assign pop      = push && (state_reg == SEND);
  assign pkt_load = (count >= START_CNT) ? START_CNT : count;

  always_comb begin
    state_next   = state_reg;
    pkt_rem_next = pkt_rem_reg;
    timer_next   = timer_reg;
    if (wr_accept || state_reg == IDLE || state_reg == GAP)
      timer_next = '0;
    else if (timer_reg != TIMER_MAX)
      timer_next = timer_reg + TW'(1);

    case (state_reg)
      IDLE: if (wr_accept) state_next = WAIT;
      WAIT: begin
        if (count >= START_CNT || timer_reg == TIMER_FIRE) begin
          state_next   = FIRST_STATE;
          pkt_rem_next = pkt_load;
        end
      end
      HDR: if (push) state_next = SEND;
      SEND: begin
        if (pop) begin
          pkt_rem_next = pkt_rem_reg - CW'(1);
          if (pkt_rem_reg == CW'(1)) state_next = GAP;
        end
      end
      GAP: begin
        // A write landing in GAP on an empty buffer must not be stranded in IDLE.
        if (count >= START_CNT) begin
          state_next   = FIRST_STATE;
          pkt_rem_next = pkt_load;
        end else if (count != '0 || wr_accept) begin
          state_next = WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    data_to_uart_node = '0;
    if (state_reg == SEND) data_to_uart_node = head;
`ifdef WLESS_FRAMER_LEN_HEADER_EN
    if (state_reg == HDR) data_to_uart_node = DATA_WIDTH'(pkt_rem_reg);
`endif
  end

  // Status flags are registered from next-state values so they track the state exactly.
  always_ff @(posedge internal_clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      timer_reg        <= '0;
      pkt_rem_reg      <= '0;
      frame_active_reg <= 1'b0;
      aux_reg          <= 1'b1;
    end else begin
      state_reg        <= state_next;
      timer_reg        <= timer_next;
      pkt_rem_reg      <= pkt_rem_next;
      frame_active_reg <= (state_next == SEND);
      aux_reg          <= (state_next == IDLE) && (count_next == '0);
    end
  end

  assign TX_use_node  = push;
  assign buffer_count = count;
  assign frame_active = frame_active_reg;
  assign AUX          = aux_reg;

endmodule

// File: tb/tb_wless_tx_framer.sv
// Self-checking bench for wless_tx_framer: directed scenarios plus randomized
// traffic checked against a queue-based packet model.
module tb_wless_tx_framer;

  localparam int DW    = 8;
  localparam int DEPTH = 512;
  localparam int START = 58;
  localparam int ENDW  = 6250;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef WLESS_FRAMER_LEN_HEADER_EN
  localparam int HDR_N = 1;
`else
  localparam int HDR_N = 0;
`endif

  logic          internal_clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_in_valid = 1'b0;
  logic          tx_enable = 1'b1;
  logic          TX_flag_node = 1'b0;
  logic          TX_use_node;
  logic [DW-1:0] data_to_uart_node;
  logic [CW-1:0] buffer_count;
  logic          buffer_full, overflow, frame_active, AUX;

  wless_tx_framer #(
    .DATA_WIDTH                  (DW),
    .BUFFER_DEPTH                (DEPTH),
    .START_WIRELESS_TRANS_VALUE  (START),
    .END_WAITING_SEND_WLESS_DATA (ENDW)
  ) dut (
    .internal_clk      (internal_clk),
    .rst               (rst),
    .data_in           (data_in),
    .data_in_valid     (data_in_valid),
    .tx_enable         (tx_enable),
    .TX_flag_node      (TX_flag_node),
    .TX_use_node       (TX_use_node),
    .data_to_uart_node (data_to_uart_node),
    .buffer_count      (buffer_count),
    .buffer_full       (buffer_full),
    .overflow          (overflow),
    .frame_active      (frame_active),
    .AUX               (AUX)
  );

  always #5 internal_clk = ~internal_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: accepted bytes queue, packet length rule, overflow rule.
  logic [DW-1:0] q[$];
  int pkt_lens[$];
  int push_total = 0;
  int pkt_n = 0, exp_len = 0, prev_occ = 0, hdr_val = 0, occ_m = 0;
  bit ovf_pend = 0, prev_fa = 0;

  always @(negedge internal_clk) begin
    if (rst) begin
      q.delete();
      ovf_pend = 0;
      prev_fa  = 0;
      pkt_n    = 0;
      prev_occ = 0;
    end else begin
      occ_m = q.size();
      check("count", buffer_count, occ_m);
      check("full", buffer_full, (occ_m == DEPTH) ? 1 : 0);
      check("overflow", overflow, ovf_pend);
      ovf_pend = 0;
      if (frame_active && !prev_fa) begin
        exp_len = HDR_N ? hdr_val : ((prev_occ < START) ? prev_occ : START);
        pkt_n   = 0;
      end
      if (!frame_active && prev_fa) begin
        check("pkt_len", pkt_n, exp_len);
        pkt_lens.push_back(pkt_n);
        $display("packet %0d: %0d bytes at %0t", pkt_lens.size(), pkt_n, $time);
      end
      if (TX_use_node) begin
        push_total++;
        check("push_gate", (tx_enable && !TX_flag_node) ? 1 : 0, 1);
        if (frame_active) begin
          check("pop_nonempty", (buffer_count != 0) ? 1 : 0, 1);
          if (q.size() != 0) begin
            check("data", data_to_uart_node, q[0]);
            void'(q.pop_front());
          end
          pkt_n++;
        end else begin
`ifdef WLESS_FRAMER_LEN_HEADER_EN
          hdr_val = data_to_uart_node;
`else
          check("push_outside_send", frame_active, 1);
`endif
        end
      end
      if (data_in_valid) begin
        if (occ_m < DEPTH) q.push_back(data_in);
        else ovf_pend = 1;
      end
      prev_occ = occ_m;
      prev_fa  = frame_active;
    end
  end

  task automatic tick();
    @(posedge internal_clk);
    #1;
  endtask

  task automatic write_seq(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      data_in       = DW'(base + i);
      data_in_valid = 1'b1;
      tick();
    end
    data_in_valid = 1'b0;
  endtask

  task automatic wait_push(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(negedge internal_clk);
      if (TX_use_node) break;
      n++;
    end
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (n < limit && !(buffer_count == 0 && AUX && !frame_active && !TX_use_node)) begin
      @(negedge internal_clk);
      n++;
    end
    check(tag, (n < limit) ? 1 : 0, 1);
    tick();
  endtask

  task automatic wait_payload(input int n_target, input int limit, output int c);
    int lim = 0;
    c = 0;
    while (c < n_target && lim < limit) begin
      @(negedge internal_clk);
      if (TX_use_node && frame_active) c++;
      lim++;
    end
  endtask

  task automatic bp_stall(input bit use_en, input int n_before, input int exp_byte);
    int c, p0;
    int fa_low = 0;
    wait_payload(n_before, 500, c);
    check("bp_reach", c, n_before);
    tick();
    if (use_en) tx_enable = 1'b0;
    else TX_flag_node = 1'b1;
    p0 = push_total;
    repeat (19) begin
      @(negedge internal_clk);
      if (!frame_active) fa_low++;
    end
    tick();
    check("bp_nopush", push_total - p0, 0);
    check("bp_active", fa_low, 0);
    tx_enable    = 1'b1;
    TX_flag_node = 1'b0;
    @(negedge internal_clk);
    check("bp_resume", TX_use_node, 1);
    check("bp_byte", data_to_uart_node, exp_byte);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, c, c70, p0, n58;
    #1 rst = 1'b1;
    #1;
    check("rst_use", TX_use_node, 0);
    check("rst_data", data_to_uart_node, 0);
    check("rst_count", buffer_count, 0);
    check("rst_full", buffer_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_fa", frame_active, 0);
    check("rst_aux", AUX, 1);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Threshold trigger
    write_seq(START, 0);
    wait_push(20, n);
    check("thr_latency", n, 1);
`ifdef WLESS_FRAMER_LEN_HEADER_EN
    check("thr_hdr", data_to_uart_node, 8'h3A);
`endif
    c = 1;
    repeat (START - 1 + HDR_N) begin
      @(negedge internal_clk);
      if (TX_use_node) c++;
    end
    check("thr_burst", c, START + HDR_N);
    wait_idle("thr_idle", 20);
    check("thr_aux", AUX, 1);

    // Idle-timeout flush and timer restart
    write_seq(5, 8'h10);
    wait_push(ENDW + 100, n);
    check("tmo_latency", n, ENDW);
    wait_idle("tmo_idle", 100);
    check("tmo_len", pkt_lens[$], 5);
    write_seq(3, 8'h20);
    p0 = push_total;
    repeat (3000) tick();
    check("tmo_hold", push_total - p0, 0);
    write_seq(1, 8'h23);
    wait_push(ENDW + 100, n);
    check("tmo_restart", n, ENDW);
    wait_idle("tmo_idle2", 100);
    check("tmo_len2", pkt_lens[$], 4);

    // Backpressure via TX_flag_node then tx_enable
    write_seq(START, 8'h40);
    bp_stall(1'b0, 10, 8'h4A);
    bp_stall(1'b1, 19, 8'h5E);
    wait_idle("bp_idle", 200);

    // Overflow and pointer wrap
    tx_enable = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      data_in       = DW'(i);
      data_in_valid = 1'b1;
      if (i == DEPTH - 1) check("ovf_not_full", buffer_full, 0);
      if (i == DEPTH) check("ovf_full", buffer_full, 1);
      tick();
    end
    data_in_valid = 1'b0;
    check("ovf_pulse", overflow, 1);
    check("ovf_count", buffer_count, DEPTH);
    tick();
    check("ovf_single", overflow, 0);
    pkt_lens.delete();
    tx_enable = 1'b1;
    wait_idle("ovf_drain", 10000);
    check("ovf_npkts", pkt_lens.size(), 9);
    n58 = 0;
    foreach (pkt_lens[k]) if (pkt_lens[k] == START) n58++;
    check("ovf_n58", n58, 8);
    check("ovf_last", pkt_lens[$], DEPTH - 8 * START);

    // Writes on every cycle while popping
    pkt_lens.delete();
    c70 = 0;
    for (int i = 0; i < 138; i++) begin
      data_in       = DW'($urandom);
      data_in_valid = 1'b1;
      if (i == 70) c70 = buffer_count;
      if (i == 110) check("sim_count_const", buffer_count, c70);
      tick();
    end
    data_in_valid = 1'b0;
    wait_idle("sim_drain", ENDW + 500);
    check("sim_npkts", pkt_lens.size(), 3);
    check("sim_len0", pkt_lens[0], START);
    check("sim_len1", pkt_lens[1], START);
    check("sim_len2", pkt_lens[2], 138 - 2 * START);

    // Randomized traffic with random flow control
    for (int i = 0; i < 3000; i++) begin
      data_in       = DW'($urandom);
      data_in_valid = ($urandom_range(0, 99) < 35);
      TX_flag_node  = ($urandom_range(0, 99) < 15);
      tx_enable     = ($urandom_range(0, 99) < 90);
      tick();
    end
    data_in_valid = 1'b0;
    TX_flag_node  = 1'b0;
    tx_enable     = 1'b1;
    wait_idle("rnd_drain", ENDW + 2000);

    // Reset in the middle of a packet
    write_seq(START, 8'h80);
    wait_payload(30, 200, c);
    check("rstm_reach", c, 30);
    tick();
    #2 rst = 1'b1;
    #1;
    check("rstm_use", TX_use_node, 0);
    check("rstm_data", data_to_uart_node, 0);
    check("rstm_count", buffer_count, 0);
    check("rstm_fa", frame_active, 0);
    check("rstm_aux", AUX, 1);
    repeat (2) tick();
    rst = 1'b0;
    p0 = push_total;
    repeat (100) tick();
    check("rstm_nopush", push_total - p0, 0);
    check("rstm_count_after", buffer_count, 0);
    check("rstm_aux_after", AUX, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
